// File: rtl/turn_manager.sv
// Turn sequencing for a two-player column game: drives the turn timer, issues board
// writes over req/ack, and auto-picks a free column from an LFSR when a turn times out.
module turn_manager #(
  parameter int unsigned NUM_COLS  = 7,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                move_valid,
  input  logic [2:0]          move_col,
  input  logic [NUM_COLS-1:0] col_full,
  input  logic                game_over,
  input  logic                timer_timeout,
  output logic                timer_enable,
  output logic                timer_reset,
  output logic                move_req,
  output logic [2:0]          move_req_col,
  output logic                move_player,
  input  logic                move_ack,
  output logic                current_player,
  output logic                auto_move,
  output logic                invalid_move,
  output logic                board_full,
  output logic                done
);

  localparam int unsigned COL_W = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TURN_START,
    S_WAIT_MOVE,
    S_AUTO_PICK,
    S_ISSUE,
    S_SETTLE,
    S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [7:0]       lfsr, lfsr_nxt;
  logic [COL_W-1:0] cand, cand_nxt;
  logic [COL_W-1:0] scan_cnt, scan_nxt;
  logic [COL_W-1:0] cand_init, cand_wrap;
  logic [7:0]       col_full_pad;
  logic             move_ok;

  logic             timer_enable_nxt, timer_reset_nxt, move_req_nxt;
  logic [COL_W-1:0] move_req_col_nxt;
  logic             move_player_nxt, current_player_nxt, auto_move_nxt;
  logic             invalid_move_nxt, board_full_nxt, done_nxt;

  // Fibonacci LFSR, x^8+x^6+x^5+x^4+1
  assign lfsr_nxt = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

  // Columns beyond NUM_COLS read as full so any out-of-range select is rejected
  always_comb begin
    col_full_pad                 = '1;
    col_full_pad[NUM_COLS-1:0]   = col_full;
  end

  assign move_ok   = (32'(move_col) < NUM_COLS) && !col_full_pad[move_col];
  assign cand_init = COL_W'(lfsr_nxt % 8'(NUM_COLS));
  assign cand_wrap = (cand == COL_W'(NUM_COLS - 1)) ? '0 : cand + COL_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_IDLE;
      lfsr           <= LFSR_SEED;
      cand           <= '0;
      scan_cnt       <= '0;
      timer_enable   <= 1'b0;
      timer_reset    <= 1'b1;
      move_req       <= 1'b0;
      move_req_col   <= '0;
      move_player    <= 1'b0;
      current_player <= 1'b0;
      auto_move      <= 1'b0;
      invalid_move   <= 1'b0;
      board_full     <= 1'b0;
      done           <= 1'b0;
    end else begin
      state          <= state_nxt;
      lfsr           <= lfsr_nxt;
      cand           <= cand_nxt;
      scan_cnt       <= scan_nxt;
      timer_enable   <= timer_enable_nxt;
      timer_reset    <= timer_reset_nxt;
      move_req       <= move_req_nxt;
      move_req_col   <= move_req_col_nxt;
      move_player    <= move_player_nxt;
      current_player <= current_player_nxt;
      auto_move      <= auto_move_nxt;
      invalid_move   <= invalid_move_nxt;
      board_full     <= board_full_nxt;
      done           <= done_nxt;
    end
  end

  // Next state plus look-ahead output decode so registered outputs track the state
  always_comb begin
    state_nxt          = state;
    cand_nxt           = cand;
    scan_nxt           = scan_cnt;
    move_req_col_nxt   = move_req_col;
    move_player_nxt    = move_player;
    current_player_nxt = current_player;
    auto_move_nxt      = auto_move;
    board_full_nxt     = board_full;
    invalid_move_nxt   = 1'b0;

    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt          = S_TURN_START;
          current_player_nxt = 1'b0;
          board_full_nxt     = 1'b0;
          auto_move_nxt      = 1'b0;
        end
      end
      S_TURN_START: state_nxt = S_WAIT_MOVE;
      S_WAIT_MOVE: begin
        if (game_over) begin
          state_nxt = S_DONE;
        end else if (move_valid && move_ok) begin
          state_nxt        = S_ISSUE;
          move_req_col_nxt = move_col;
          move_player_nxt  = current_player;
          auto_move_nxt    = 1'b0;
        end else if (move_valid) begin
          invalid_move_nxt = 1'b1;
        end else if (timer_timeout) begin
          state_nxt = S_AUTO_PICK;
          cand_nxt  = cand_init;
          scan_nxt  = '0;
        end
      end
      S_AUTO_PICK: begin
        if (!col_full_pad[cand]) begin
          state_nxt        = S_ISSUE;
          move_req_col_nxt = cand;
          move_player_nxt  = current_player;
          auto_move_nxt    = 1'b1;
        end else if (scan_cnt == COL_W'(NUM_COLS - 1)) begin
          state_nxt      = S_DONE;
          board_full_nxt = 1'b1;
        end else begin
          cand_nxt = cand_wrap;
          scan_nxt = scan_cnt + COL_W'(1);
        end
      end
      S_ISSUE: begin
        if (move_ack) state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        if (game_over) begin
          state_nxt = S_DONE;
        end else begin
          state_nxt          = S_TURN_START;
          current_player_nxt = ~current_player;
          auto_move_nxt      = 1'b0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    timer_reset_nxt  = (state_nxt == S_IDLE) || (state_nxt == S_TURN_START) ||
                       (state_nxt == S_DONE);
    timer_enable_nxt = (state_nxt == S_WAIT_MOVE);
    move_req_nxt     = (state_nxt == S_ISSUE);
    done_nxt         = (state_nxt == S_DONE);
  end

endmodule

// File: tb/tb_turn_manager.sv
// Directed bench for turn_manager: timer control, req/ack handshake, rejected moves,
// LFSR auto-pick scan, board-full termination, game over and asynchronous reset.
module tb_turn_manager;

  localparam int unsigned NUM_COLS = 7;
  localparam logic [7:0]  SEED     = 8'hA5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       move_valid = 1'b0;
  logic [2:0] move_col = 3'd0;
  logic [6:0] col_full = 7'd0;
  logic       game_over = 1'b0;
  logic       timer_timeout = 1'b0;
  logic       move_ack = 1'b0;
  logic       timer_enable, timer_reset, move_req, move_player;
  logic [2:0] move_req_col;
  logic       current_player, auto_move, invalid_move, board_full, done;

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] lfsr_m;
  bit         found;

  turn_manager #(.NUM_COLS(NUM_COLS), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst(rst), .start(start), .move_valid(move_valid), .move_col(move_col),
    .col_full(col_full), .game_over(game_over), .timer_timeout(timer_timeout),
    .timer_enable(timer_enable), .timer_reset(timer_reset), .move_req(move_req),
    .move_req_col(move_req_col), .move_player(move_player), .move_ack(move_ack),
    .current_player(current_player), .auto_move(auto_move), .invalid_move(invalid_move),
    .board_full(board_full), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // Reference LFSR sequence, free-running from reset like the game's
  always @(posedge clk or posedge rst) begin
    if (rst) lfsr_m <= SEED;
    else     lfsr_m <= lfsr_step(lfsr_m);
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset values
    @(negedge clk);
    @(negedge clk);
    check("rst_timer_reset", 8'(timer_reset), 8'd1);
    check("rst_timer_enable", 8'(timer_enable), 8'd0);
    check("rst_move_req", 8'(move_req), 8'd0);
    check("rst_player", 8'(current_player), 8'd0);
    check("rst_done", 8'(done), 8'd0);
    check("rst_board_full", 8'(board_full), 8'd0);
    rst = 1'b0;
    tick();
    check("idle_timer_reset", 8'(timer_reset), 8'd1);

    // Start: one TURN_START cycle then timer runs
    start = 1'b1;
    tick();
    start = 1'b0;
    check("ts_timer_reset", 8'(timer_reset), 8'd1);
    check("ts_timer_enable", 8'(timer_enable), 8'd0);
    check("ts_player", 8'(current_player), 8'd0);
    tick();
    check("wm_timer_reset", 8'(timer_reset), 8'd0);
    check("wm_timer_enable", 8'(timer_enable), 8'd1);

    // Player 1 moves column 3, ack delayed
    move_valid = 1'b1; move_col = 3'd3; col_full = 7'd0;
    tick();
    move_valid = 1'b0;
    check("p1_req", 8'(move_req), 8'd1);
    check("p1_col", 8'(move_req_col), 8'd3);
    check("p1_player", 8'(move_player), 8'd0);
    check("p1_auto", 8'(auto_move), 8'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("p1_req_hold", 8'(move_req), 8'd1);
      check("p1_col_hold", 8'(move_req_col), 8'd3);
    end
    move_ack = 1'b1;
    tick();
    move_ack = 1'b0;
    check("p1_req_drop", 8'(move_req), 8'd0);
    check("p1_settle_treset", 8'(timer_reset), 8'd0);
    tick();
    check("p1_treset_pulse", 8'(timer_reset), 8'd1);
    check("p1_player_toggle", 8'(current_player), 8'd1);
    tick();
    check("p2_wait_enable", 8'(timer_enable), 8'd1);

    // Rejected moves: out-of-range column, then full column
    move_valid = 1'b1; move_col = 3'd7;
    tick();
    move_valid = 1'b0;
    check("inv7_pulse", 8'(invalid_move), 8'd1);
    check("inv7_enable", 8'(timer_enable), 8'd1);
    check("inv7_req", 8'(move_req), 8'd0);
    tick();
    check("inv7_pulse_end", 8'(invalid_move), 8'd0);
    col_full = 7'b0000100; move_valid = 1'b1; move_col = 3'd2;
    tick();
    move_valid = 1'b0;
    check("invfull_pulse", 8'(invalid_move), 8'd1);
    check("invfull_req", 8'(move_req), 8'd0);
    tick();
    check("invfull_pulse_end", 8'(invalid_move), 8'd0);
    check("invfull_enable", 8'(timer_enable), 8'd1);

    // Timeout timed so the first candidate is column 1; columns 1..5 full
    col_full = 7'b0111110;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      if ((int'(lfsr_step(lfsr_m)) % NUM_COLS) == 1) found = 1'b1;
      else tick();
    end
    check("cand1_found", 8'(found), 8'd1);
    timer_timeout = 1'b1;
    tick();
    timer_timeout = 1'b0;
    check("ap_enable_off", 8'(timer_enable), 8'd0);
    for (int i = 0; i < 5; i++) tick();
    check("ap_still_scanning", 8'(move_req), 8'd0);
    tick();
    check("ap_req", 8'(move_req), 8'd1);
    check("ap_col", 8'(move_req_col), 8'd6);
    check("ap_auto", 8'(auto_move), 8'd1);
    check("ap_player", 8'(move_player), 8'd1);
    move_ack = 1'b1;
    tick();
    move_ack = 1'b0;
    check("ap_req_drop", 8'(move_req), 8'd0);
    tick();
    check("ap_player_toggle", 8'(current_player), 8'd0);
    check("ap_auto_clear", 8'(auto_move), 8'd0);
    tick();

    // Player move coincident with timeout; then game over in SETTLE
    col_full = 7'd0; move_valid = 1'b1; move_col = 3'd0; timer_timeout = 1'b1;
    tick();
    move_valid = 1'b0; timer_timeout = 1'b0;
    check("co_req", 8'(move_req), 8'd1);
    check("co_col", 8'(move_req_col), 8'd0);
    check("co_auto", 8'(auto_move), 8'd0);
    move_ack = 1'b1;
    tick();
    move_ack = 1'b0;
    game_over = 1'b1;
    tick();
    game_over = 1'b0;
    check("go_done", 8'(done), 8'd1);
    check("go_player_kept", 8'(current_player), 8'd0);
    check("go_treset", 8'(timer_reset), 8'd1);

    // Restart, then timeout with every column full
    start = 1'b1;
    tick();
    start = 1'b0;
    check("rs_done_clear", 8'(done), 8'd0);
    check("rs_player", 8'(current_player), 8'd0);
    tick();
    col_full = 7'h7F; timer_timeout = 1'b1;
    tick();
    timer_timeout = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("full_no_req", 8'(move_req), 8'd0);
    end
    check("full_not_done_yet", 8'(done), 8'd0);
    tick();
    check("full_done", 8'(done), 8'd1);
    check("full_board_full", 8'(board_full), 8'd1);
    check("full_req", 8'(move_req), 8'd0);

    // Asynchronous reset while a request is pending
    start = 1'b1;
    tick();
    start = 1'b0;
    check("rs2_board_full_clear", 8'(board_full), 8'd0);
    tick();
    col_full = 7'd0; move_valid = 1'b1; move_col = 3'd5;
    tick();
    move_valid = 1'b0;
    check("ar_req_before", 8'(move_req), 8'd1);
    #2 rst = 1'b1;
    #1;
    check("ar_req", 8'(move_req), 8'd0);
    check("ar_treset", 8'(timer_reset), 8'd1);
    check("ar_tenable", 8'(timer_enable), 8'd0);
    check("ar_done", 8'(done), 8'd0);
    check("ar_col", 8'(move_req_col), 8'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("ar_idle_treset", 8'(timer_reset), 8'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
